// File: rtl/uart_rx_line_assembler.sv
// uart_rx_line_assembler
// Collects bytes from the UART RX controller into an LF-terminated text line,
// holds the finished line in a buffer and hands it to the command parser via a
// valid/ack handshake with registered random-access readout.
// Optional build macro: UART_LINE_COMMENT_STRIP_EN strips ';' and '(...)'
// comments before storing.
module uart_rx_line_assembler #(
    parameter int DATA_SIZE    = 8,
    parameter int MAX_LINE_LEN = 64,
    parameter int LEN_BITS     = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] rx_data,
    input  logic                 rx_done,
    output logic                 line_valid,
    output logic [LEN_BITS-1:0]  line_len,
    output logic                 line_overflow,
    output logic                 line_dropped,
    input  logic [LEN_BITS-1:0]  rd_addr,
    output logic [DATA_SIZE-1:0] rd_data,
    input  logic                 line_ack
);

    localparam int ADDR_BITS = (MAX_LINE_LEN > 1) ? $clog2(MAX_LINE_LEN) : 1;
    localparam logic [LEN_BITS-1:0]  MAX_COUNT = LEN_BITS'(MAX_LINE_LEN);
    localparam logic [DATA_SIZE-1:0] CHAR_CR   = DATA_SIZE'(8'h0D);
    localparam logic [DATA_SIZE-1:0] CHAR_LF   = DATA_SIZE'(8'h0A);

    typedef enum logic [1:0] {
        COLLECT,
        DISCARD,
        READY
    } state_t;

    state_t               state, state_next;
    logic [LEN_BITS-1:0]  count, count_next, len_next;
    logic                 ovf_next, dropped_next, wr_en;
    logic [DATA_SIZE-1:0] buffer [MAX_LINE_LEN];

`ifdef UART_LINE_COMMENT_STRIP_EN
    localparam logic [DATA_SIZE-1:0] CHAR_SEMI   = DATA_SIZE'(8'h3B);
    localparam logic [DATA_SIZE-1:0] CHAR_LPAREN = DATA_SIZE'(8'h28);
    localparam logic [DATA_SIZE-1:0] CHAR_RPAREN = DATA_SIZE'(8'h29);

    typedef enum logic [1:0] {
        CMT_NONE,
        CMT_SEMI,
        CMT_PAREN
    } comment_t;

    comment_t comment, comment_next;
`endif

    // The line is presented for exactly as long as the FSM sits in READY.
    assign line_valid = (state == READY);

    // Next-state and next-value logic for the line FSM and its bookkeeping.
    always_comb begin
        state_next   = state;
        count_next   = count;
        len_next     = line_len;
        ovf_next     = line_overflow;
        dropped_next = line_dropped;
        wr_en        = 1'b0;
`ifdef UART_LINE_COMMENT_STRIP_EN
        comment_next = comment;
`endif
        case (state)
            COLLECT: begin
                if (rx_done) begin
`ifdef UART_LINE_COMMENT_STRIP_EN
                    if (comment != CMT_NONE && rx_data != CHAR_LF) begin
                        if (comment == CMT_PAREN && rx_data == CHAR_RPAREN) begin
                            comment_next = CMT_NONE;
                        end
                    end else if (rx_data == CHAR_SEMI) begin
                        comment_next = CMT_SEMI;
                    end else if (rx_data == CHAR_LPAREN) begin
                        comment_next = CMT_PAREN;
                    end else
`endif
                    if (rx_data == CHAR_LF) begin
`ifdef UART_LINE_COMMENT_STRIP_EN
                        comment_next = CMT_NONE;
`endif
                        if (count != '0) begin
                            len_next   = count;
                            state_next = READY;
                        end
                    end else if (rx_data != CHAR_CR) begin
                        if (count < MAX_COUNT) begin
                            wr_en      = 1'b1;
                            count_next = count + 1'b1;
                        end else begin
                            ovf_next   = 1'b1;
                            state_next = DISCARD;
                        end
                    end
                end
            end
            DISCARD: begin
                if (rx_done && rx_data == CHAR_LF) begin
                    len_next   = MAX_COUNT;
                    state_next = READY;
                end
            end
            READY: begin
                if (line_ack) begin
                    state_next   = COLLECT;
                    ovf_next     = 1'b0;
                    dropped_next = 1'b0;
                    count_next   = '0;
                end else if (rx_done) begin
                    dropped_next = 1'b1;
                end
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    // State and flag registers; reset throws away any partial line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= COLLECT;
            count         <= '0;
            line_len      <= '0;
            line_overflow <= 1'b0;
            line_dropped  <= 1'b0;
`ifdef UART_LINE_COMMENT_STRIP_EN
            comment       <= CMT_NONE;
`endif
        end else begin
            state         <= state_next;
            count         <= count_next;
            line_len      <= len_next;
            line_overflow <= ovf_next;
            line_dropped  <= dropped_next;
`ifdef UART_LINE_COMMENT_STRIP_EN
            comment       <= comment_next;
`endif
        end
    end

    // Line buffer write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            buffer[count[ADDR_BITS-1:0]] <= rx_data;
        end
    end

    // Registered readout; addresses past the buffer read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_addr < MAX_COUNT) begin
            rd_data <= buffer[rd_addr[ADDR_BITS-1:0]];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_uart_rx_line_assembler.sv
// tb_uart_rx_line_assembler
// Scoreboard bench: the stimulus process streams lines and pushes the lines a
// reference model predicts; a monitor pops and checks each presented line.
`timescale 1ns/1ps
module tb_uart_rx_line_assembler;

    localparam int MAX_LINE_LEN = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data_s, rx_data_m, rx_data;
    logic       rx_done_s, rx_done_m, rx_done;
    logic       line_valid, line_overflow, line_dropped, line_ack;
    logic [6:0] line_len, rd_addr;
    logic [7:0] rd_data;

    int total = 0;
    int bad = 0;
    int lines_done = 0;

    int         exp_len_q[$];
    bit         exp_ovf_q[$];
    int         exp_mode_q[$];
    logic [7:0] exp_byte_q[$];

    assign rx_done = rx_done_s | rx_done_m;
    assign rx_data = rx_done_m ? rx_data_m : rx_data_s;

    uart_rx_line_assembler #(
        .DATA_SIZE(8),
        .MAX_LINE_LEN(MAX_LINE_LEN),
        .LEN_BITS(7)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .line_valid(line_valid),
        .line_len(line_len),
        .line_overflow(line_overflow),
        .line_dropped(line_dropped),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .line_ack(line_ack)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: drop CR, strip comments when enabled, keep the first 64 bytes.
    task automatic model_line(input logic [7:0] raw[$], output logic [7:0] kept[$], output bit ovf);
        logic [7:0] full[$];
`ifdef UART_LINE_COMMENT_STRIP_EN
        int cmt = 0;
`endif
        full = {};
        foreach (raw[i]) begin
            if (raw[i] == 8'h0D) continue;
`ifdef UART_LINE_COMMENT_STRIP_EN
            if (cmt == 1) continue;
            if (cmt == 2) begin
                if (raw[i] == 8'h29) cmt = 0;
                continue;
            end
            if (raw[i] == 8'h3B) begin cmt = 1; continue; end
            if (raw[i] == 8'h28) begin cmt = 2; continue; end
`endif
            full.push_back(raw[i]);
        end
        ovf = full.size() > MAX_LINE_LEN;
        kept = {};
        for (int i = 0; i < full.size() && i < MAX_LINE_LEN; i++) kept.push_back(full[i]);
    endtask

    task automatic str_to_q(input string s, output logic [7:0] q[$]);
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_s = b;
        rx_done_s = 1'b1;
        @(negedge clk);
        rx_done_s = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_valid", line_valid, 0);
        checkOutput("rst_len", line_len, 0);
        checkOutput("rst_ovf", line_overflow, 0);
        checkOutput("rst_dropped", line_dropped, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Stream one line (raw bytes, LF appended) and queue what should appear.
    task automatic applyStimulus(input logic [7:0] raw[$], input int mode);
        logic [7:0] kept[$];
        bit ovf;
        int target;
        model_line(raw, kept, ovf);
        target = lines_done + 1;
        if (kept.size() > 0) begin
            exp_len_q.push_back(kept.size());
            exp_ovf_q.push_back(ovf);
            exp_mode_q.push_back(mode);
            foreach (kept[i]) exp_byte_q.push_back(kept[i]);
        end
        foreach (raw[i]) begin
            send_byte(raw[i]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        checkOutput("valid_before_lf", line_valid, 0);
        send_byte(8'h0A);
        checkOutput("valid_after_lf", line_valid, (kept.size() > 0) ? 1 : 0);
        if (kept.size() > 0) begin
            for (int c = 0; c < 2000 && lines_done < target; c++) @(negedge clk);
            if (lines_done < target) begin
                total++;
                bad++;
                $display("[TB] FAIL ack_timeout lines_done=%0d required=%0d", lines_done, target);
            end
        end else begin
            repeat (3) @(negedge clk);
            checkOutput("no_line_valid", line_valid, 0);
        end
    endtask

    // Monitor: pop each expected line when the DUT presents one and check it.
    initial begin
        int len, mode;
        bit ovf;
        logic [7:0] first;
        rd_addr = '0;
        line_ack = 1'b0;
        rx_done_m = 1'b0;
        rx_data_m = '0;
        forever begin
            @(negedge clk);
            if (!reset && line_valid) begin
                if (exp_len_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_line line_len=%0d required=none", line_len);
                    line_ack = 1'b1;
                    @(negedge clk);
                    line_ack = 1'b0;
                end else begin
                    len = exp_len_q.pop_front();
                    ovf = exp_ovf_q.pop_front();
                    mode = exp_mode_q.pop_front();
                    first = exp_byte_q[0];
                    checkOutput("line_len", line_len, len);
                    checkOutput("line_overflow", line_overflow, ovf);
                    checkOutput("line_dropped_clear", line_dropped, 0);
                    for (int i = 0; i < len; i++) begin
                        rd_addr = 7'(i);
                        @(negedge clk);
                        checkOutput("rd_data", rd_data, exp_byte_q.pop_front());
                    end
                    rd_addr = 7'd64;
                    @(negedge clk);
                    checkOutput("rd_data_addr64", rd_data, 0);
                    rd_addr = 7'd127;
                    @(negedge clk);
                    checkOutput("rd_data_addr127", rd_data, 0);
                    if (mode == 1) begin
                        rx_data_m = 8'h58;
                        rx_done_m = 1'b1;
                        @(negedge clk);
                        rx_data_m = 8'h0A;
                        @(negedge clk);
                        rx_done_m = 1'b0;
                        rd_addr = '0;
                        @(negedge clk);
                        checkOutput("dropped_set", line_dropped, 1);
                        checkOutput("held_valid", line_valid, 1);
                        checkOutput("held_len", line_len, len);
                        checkOutput("held_ovf", line_overflow, ovf);
                        checkOutput("held_byte0", rd_data, first);
                    end
                    line_ack = 1'b1;
                    if (mode == 2) begin
                        rx_data_m = 8'h5A;
                        rx_done_m = 1'b1;
                    end
                    @(negedge clk);
                    line_ack = 1'b0;
                    rx_done_m = 1'b0;
                    checkOutput("ack_valid", line_valid, 0);
                    checkOutput("ack_dropped", line_dropped, 0);
                    checkOutput("ack_ovf", line_overflow, 0);
                    lines_done++;
                end
            end
        end
    end

    // Stimulus: directed cases from the plan, then randomized lines.
    initial begin
        logic [7:0] raw[$];
        string alpha;
        alpha = "GMXYZ0123456789 .-";
        reset = 1'b1;
        rx_data_s = '0;
        rx_done_s = 1'b0;
        @(negedge clk);
        pulse_reset();

        str_to_q("G1 X10", raw);
        raw.push_back(8'h0D);
        applyStimulus(raw, 0);

        raw = {};
        applyStimulus(raw, 0);
        raw = {8'h0D};
        applyStimulus(raw, 0);

        raw = {};
        repeat (70) raw.push_back(8'h41);
        applyStimulus(raw, 0);
        str_to_q("M2", raw);
        applyStimulus(raw, 0);

        raw = {};
        repeat (64) raw.push_back(8'h42);
        applyStimulus(raw, 0);
        raw.push_back(8'h43);
        applyStimulus(raw, 0);

        str_to_q("Q7", raw);
        applyStimulus(raw, 1);
        str_to_q("G2", raw);
        applyStimulus(raw, 0);

        str_to_q("G3", raw);
        applyStimulus(raw, 2);
        str_to_q("G4", raw);
        applyStimulus(raw, 0);

        str_to_q("G0", raw);
        foreach (raw[i]) send_byte(raw[i]);
        pulse_reset();
        str_to_q("M3", raw);
        applyStimulus(raw, 0);

`ifdef UART_LINE_COMMENT_STRIP_EN
        str_to_q("G1 (c) X5;tail", raw);
        applyStimulus(raw, 0);
        str_to_q(";only", raw);
        applyStimulus(raw, 0);
`endif

        for (int n = 0; n < 40; n++) begin
            int len;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 72) : $urandom_range(0, 20);
            raw = {};
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 15))
                    0: raw.push_back(8'h0D);
                    1: raw.push_back(8'h3B);
                    2: raw.push_back(8'h28);
                    3: raw.push_back(8'h29);
                    default: raw.push_back(alpha[$urandom_range(0, alpha.len() - 1)]);
                endcase
            end
            applyStimulus(raw, $urandom_range(0, 2));
        end

        repeat (5) @(negedge clk);
        checkOutput("pending_lines", exp_len_q.size(), 0);
        checkOutput("final_valid", line_valid, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_line_assembler.md
Name: uart_rx_line_assembler

Overview:
- Sits directly downstream of the UART RX controller.
- Consumes each received byte (`rx_data` qualified by the one-cycle `rx_done` strobe) and assembles bytes into a text line terminated by LF.
- Stores the line in an internal buffer and offers it to the command parser through a valid/ack handshake with random-access byte readout.
- Decouples per-byte UART timing from per-line G-code parsing.

Parameters:
- DATA_SIZE, 8, byte width; must match the RX controller data size.
- MAX_LINE_LEN, 64, buffer depth in bytes (maximum stored characters per line).
- LEN_BITS, 7, width of length/address fields; equals clog2(MAX_LINE_LEN+1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  DATA_SIZE  received byte; valid only when rx_done=1.
- rx_done  input  1  one-cycle strobe: rx_data holds a new byte.
- line_valid  output  1  a complete line is held in the buffer.
- line_len  output  LEN_BITS  number of stored bytes; stable while line_valid=1.
- line_overflow  output  1  held line was truncated at MAX_LINE_LEN; stable while line_valid=1.
- line_dropped  output  1  sticky: at least one byte arrived while a line was held; cleared by line_ack.
- rd_addr  input  LEN_BITS  byte index to read, 0..line_len-1.
- rd_data  output  DATA_SIZE  buffer[rd_addr], registered, 1-cycle latency.
- line_ack  input  1  one-cycle pulse from the consumer: release the line.

Behaviour:
- Reset:
  - state=COLLECT, write count=0.
  - line_valid=0, line_len=0, line_overflow=0, line_dropped=0, rd_data=0.
  - Buffer contents are don't-care.
  - A reset mid-line discards the partial line.
- States: COLLECT, DISCARD, READY.
- COLLECT, on rx_done:
  - CR (0x0D): ignored.
  - LF (0x0A) with count=0: ignored. Empty lines are never presented.
  - LF with count>0: line_len<=count, line_valid<=1 next cycle, state->READY.
  - Any other byte with count<MAX_LINE_LEN: buffer[count]<=byte, count<=count+1.
  - Any other byte with count==MAX_LINE_LEN: byte not stored, overflow flag<=1, state->DISCARD.
- DISCARD:
  - All bytes except LF are dropped.
  - LF: present the truncated line (line_len=MAX_LINE_LEN, line_overflow=1), state->READY.
- READY:
  - line_valid=1. line_len and line_overflow are held.
  - rx_done sets line_dropped; the byte is lost.
  - line_ack: line_valid<=0, line_overflow<=0, line_dropped<=0, count<=0, state->COLLECT on the next cycle.
- line_ack while not READY: ignored.
- Simultaneous rx_done and line_ack in READY:
  - The ack is processed.
  - The byte is dropped and does not set line_dropped (the flag is cleared).
- Latency: line_valid rises exactly 1 cycle after the rx_done cycle carrying the terminating LF.
- rd_data:
  - Updates every cycle from rd_addr, regardless of state.
  - Contents are defined only for rd_addr<line_len.
  - rd_addr>=MAX_LINE_LEN returns 0.
- Counters saturate and never wrap. count width is LEN_BITS.

Optional Feature:
- Macro: UART_LINE_COMMENT_STRIP_EN.
- Defined:
  - In COLLECT, a ';' (0x3B) enters comment mode. It and all following bytes up to LF are not stored and do not count toward overflow.
  - A '(' (0x28) enters comment mode until ')' (0x29) or LF.
  - LF exits comment mode and terminates normally. A line that is empty after stripping is suppressed.
  - Comment mode is cleared by reset and by line termination.
- Undefined: ';', '(' and ')' are stored like any other byte. No comment-mode state exists.

Test Plan:
- Stream "G1 X10\r\n" as 8 rx_done strobes -> line_valid 1 cycle after LF; line_len=6; rd_addr 0..5 returns 0x47,0x31,0x20,0x58,0x31,0x30 each 1 cycle later; line_overflow=0.
- "\n", "\r\n" alone -> line_valid never asserts; count stays 0.
- 70 'A' bytes then LF, MAX_LINE_LEN=64 -> line_len=64, line_overflow=1, all 64 reads 0x41; after line_ack, "M2\n" -> line_len=2, line_overflow=0.
- While READY, send "X\n" -> line_dropped=1 and the held line is unchanged; pulse line_ack -> all flags 0; next line assembles from empty.
- rx_done and line_ack in the same cycle -> line released, line_dropped=0, byte lost; reset asserted mid-line after "G0" -> next "M3\n" gives line_len=2, rd_data[0]=0x4D.
- With UART_LINE_COMMENT_STRIP_EN, "G1 (c) X5;tail\n" -> line_len=6 reading "G1  X5"; ";only\n" -> no line_valid.
